// File: rtl/pipectrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// ALU operand forward-select codes and default timing parameters.
package pipectrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MEMWAIT = 2'b10,
    ST_ERROR   = 2'b11
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int INITCYC_DEF = 4;
  localparam int MAXWAIT_DEF = 15;

endpackage

// File: rtl/pipectrl_fwdunit.sv
// Forwarding select for one ALU operand.
// Ports:
//   rs          - source register of the operand held in ID/EX
//   exmemregwr  - EX/MEM writes the register file
//   exmemrd     - EX/MEM destination register
//   memwbregwr  - MEM/WB writes the register file
//   memwbrd     - MEM/WB destination register
//   sel         - 00 regfile, 10 EX/MEM, 01 MEM/WB
module fwdunit
  import pipectrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       exmemregwr,
  input  logic [4:0] exmemrd,
  input  logic       memwbregwr,
  input  logic [4:0] memwbrd,
  output logic [1:0] sel
);

  // The younger result (EX/MEM) takes precedence; r0 is hardwired zero.
  always_comb begin
    sel = FWD_REG;
    if (exmemregwr && (exmemrd != 5'd0) && (exmemrd == rs))
      sel = FWD_EXMEM;
    else if (memwbregwr && (memwbrd != 5'd0) && (memwbrd == rs))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipectrl.sv
// Pipeline hazard controller: post-reset flush sequencing, load-use stall,
// taken-branch flush, data-memory wait freeze with timeout, and operand
// forwarding selects.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ifidrs/ifidrt       - source fields in IF/ID
//   idexrs/idexrt       - source fields in ID/EX (idexrt is load destination)
//   idexmemread         - ID/EX holds a load
//   branchtaken         - branch/jump resolved taken in EX
//   exmemregwr/exmemrd  - EX/MEM register write and destination
//   memwbregwr/memwbrd  - MEM/WB register write and destination
//   dmreq/dmready       - data-memory request / completion
//   pcwe..memwbwe       - stage load enables
//   ifidflush/idexflush/memwbbubble - stage NOP/bubble inserts
//   forwarda/forwardb   - ALU operand forward selects
//   dmerr               - sticky data-memory timeout
//   state               - current FSM state
//
// state   | meaning
// INIT    | flushing unreset pipeline registers, PC held
// RUN     | normal operation, hazards handled combinationally
// MEMWAIT | data memory stalled, pipeline frozen, counting wait cycles
// ERROR   | data memory timed out, pipeline halted until reset
module pipectrl
  import pipectrl_pkg::*;
#(
  parameter int INITCYC = INITCYC_DEF,
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ifidrs,
  input  logic [4:0] ifidrt,
  input  logic [4:0] idexrs,
  input  logic [4:0] idexrt,
  input  logic       idexmemread,
  input  logic       branchtaken,
  input  logic       exmemregwr,
  input  logic [4:0] exmemrd,
  input  logic       memwbregwr,
  input  logic [4:0] memwbrd,
  input  logic       dmreq,
  input  logic       dmready,
  output logic       pcwe,
  output logic       ifidwe,
  output logic       ifidflush,
  output logic       idexwe,
  output logic       idexflush,
  output logic       exmemwe,
  output logic       memwbwe,
  output logic       memwbbubble,
  output logic [1:0] forwarda,
  output logic [1:0] forwardb,
  output logic       dmerr,
  output logic [1:0] state
);

  localparam int INITW = $clog2(INITCYC + 1);
  localparam int WAITW = $clog2(MAXWAIT + 1);

  state_t             state_q, state_nxt, state_eff;
  logic [INITW-1:0]   initcnt_q, initcnt_nxt;
  logic [WAITW-1:0]   waitcnt_q, waitcnt_nxt;
  logic               dmerr_q, dmerr_nxt;
  logic               freeze, loaduse;

  assign freeze  = dmreq && !dmready;
  assign loaduse = idexmemread && (idexrt != 5'd0) &&
                   ((idexrt == ifidrs) || (idexrt == ifidrt));

  // Outputs track INIT while reset is asserted, regardless of stored state.
  assign state_eff = rst ? ST_INIT : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      initcnt_q <= '0;
      waitcnt_q <= '0;
      dmerr_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      initcnt_q <= initcnt_nxt;
      waitcnt_q <= waitcnt_nxt;
      dmerr_q   <= dmerr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    initcnt_nxt = initcnt_q;
    waitcnt_nxt = waitcnt_q;
    dmerr_nxt   = dmerr_q;
    case (state_q)
      ST_INIT: begin
        if (initcnt_q == INITW'(INITCYC - 1)) begin
          state_nxt   = ST_RUN;
          initcnt_nxt = '0;
        end else begin
          initcnt_nxt = initcnt_q + 1'b1;
        end
      end
      ST_RUN, ST_MEMWAIT: begin
        if (freeze) begin
          waitcnt_nxt = waitcnt_q + 1'b1;
          if (waitcnt_nxt == WAITW'(MAXWAIT)) begin
            state_nxt = ST_ERROR;
            dmerr_nxt = 1'b1;
          end else begin
            state_nxt = ST_MEMWAIT;
          end
        end else begin
          state_nxt   = ST_RUN;
          waitcnt_nxt = '0;
        end
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    pcwe        = 1'b1;
    ifidwe      = 1'b1;
    idexwe      = 1'b1;
    exmemwe     = 1'b1;
    memwbwe     = 1'b1;
    ifidflush   = 1'b0;
    idexflush   = 1'b0;
    memwbbubble = 1'b0;
    case (state_eff)
      ST_INIT: begin
        // exmemwe stays high so the idexflush bubble propagates into EX/MEM.
        pcwe        = 1'b0;
        ifidflush   = 1'b1;
        idexflush   = 1'b1;
        memwbbubble = 1'b1;
      end
      ST_RUN, ST_MEMWAIT: begin
        if (freeze) begin
          // MEM/WB keeps loading bubbles so no stale writeback repeats.
          pcwe        = 1'b0;
          ifidwe      = 1'b0;
          idexwe      = 1'b0;
          exmemwe     = 1'b0;
          memwbbubble = 1'b1;
        end else if (state_eff == ST_RUN && branchtaken) begin
          ifidflush = 1'b1;
          idexflush = 1'b1;
        end else if (state_eff == ST_RUN && loaduse) begin
          pcwe      = 1'b0;
          ifidwe    = 1'b0;
          idexflush = 1'b1;
        end
      end
      ST_ERROR: begin
        pcwe        = 1'b0;
        ifidwe      = 1'b0;
        idexwe      = 1'b0;
        exmemwe     = 1'b0;
        memwbbubble = 1'b1;
      end
      default: ;
    endcase
  end

  fwdunit u_fwda (
    .rs         (idexrs),
    .exmemregwr (exmemregwr),
    .exmemrd    (exmemrd),
    .memwbregwr (memwbregwr),
    .memwbrd    (memwbrd),
    .sel        (forwarda)
  );

  fwdunit u_fwdb (
    .rs         (idexrt),
    .exmemregwr (exmemregwr),
    .exmemrd    (exmemrd),
    .memwbregwr (memwbregwr),
    .memwbrd    (memwbrd),
    .sel        (forwardb)
  );

  assign dmerr = dmerr_q;
  assign state = state_q;

endmodule

// File: tb/tb_pipectrl.sv
module tb_pipectrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifidrs, ifidrt, idexrs, idexrt, exmemrd, memwbrd;
  logic       idexmemread, branchtaken, exmemregwr, memwbregwr, dmreq, dmready;
  logic       pcwe, ifidwe, ifidflush, idexwe, idexflush, exmemwe, memwbwe, memwbbubble;
  logic [1:0] forwarda, forwardb, state;
  logic       dmerr;

  int errors = 0;
  int checks = 0;

  pipectrl dut (
    .clk(clk), .rst(rst),
    .ifidrs(ifidrs), .ifidrt(ifidrt), .idexrs(idexrs), .idexrt(idexrt),
    .idexmemread(idexmemread), .branchtaken(branchtaken),
    .exmemregwr(exmemregwr), .exmemrd(exmemrd),
    .memwbregwr(memwbregwr), .memwbrd(memwbrd),
    .dmreq(dmreq), .dmready(dmready),
    .pcwe(pcwe), .ifidwe(ifidwe), .ifidflush(ifidflush),
    .idexwe(idexwe), .idexflush(idexflush), .exmemwe(exmemwe),
    .memwbwe(memwbwe), .memwbbubble(memwbbubble),
    .forwarda(forwarda), .forwardb(forwardb),
    .dmerr(dmerr), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed #1 after a rising edge; outputs sampled #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {pcwe,ifidwe,idexwe,exmemwe,memwbwe,ifidflush,idexflush,memwbbubble}
  function automatic logic [7:0] ctl();
    return {pcwe, ifidwe, idexwe, exmemwe, memwbwe, ifidflush, idexflush, memwbbubble};
  endfunction

  localparam logic [7:0] C_INIT   = 8'b0111_1111;
  localparam logic [7:0] C_RUN    = 8'b1111_1000;
  localparam logic [7:0] C_FREEZE = 8'b0000_1001;
  localparam logic [7:0] C_LDUSE  = 8'b0011_1010;
  localparam logic [7:0] C_BRANCH = 8'b1111_1110;

  initial begin
    rst = 1'b1;
    {ifidrs, ifidrt, idexrs, idexrt, exmemrd, memwbrd} = '0;
    {idexmemread, branchtaken, exmemregwr, memwbregwr, dmreq, dmready} = '0;
    #1;
    chk("ctl_during_rst", ctl(), C_INIT);
    step();
    rst = 1'b0;
    #1;
    chk("state_after_rst", {6'd0, state}, 8'h00);
    chk("dmerr_after_rst", {7'd0, dmerr}, 8'h00);
    chk("ctl_init", ctl(), C_INIT);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("state_init_hold", {6'd0, state}, 8'h00);
    end
    step();
    chk("state_run", {6'd0, state}, 8'h01);
    chk("ctl_run", ctl(), C_RUN);

    // load-use on rs, then bubble clears it
    idexmemread = 1'b1; idexrt = 5'd5; ifidrs = 5'd5;
    #1 chk("ldusers", ctl(), C_LDUSE);
    step();
    idexmemread = 1'b0;
    #1 chk("lduse_one_cycle", ctl(), C_RUN);
    // load-use on rt
    idexmemread = 1'b1; idexrt = 5'd9; ifidrs = 5'd0; ifidrt = 5'd9;
    #1 chk("ldusert", ctl(), C_LDUSE);
    // r0 destination never stalls
    idexrt = 5'd0; ifidrt = 5'd0; ifidrs = 5'd0;
    #1 chk("lduse_r0", ctl(), C_RUN);
    // branch overrides load-use
    idexrt = 5'd5; ifidrs = 5'd5; branchtaken = 1'b1;
    #1 chk("branch_over_lduse", ctl(), C_BRANCH);
    idexmemread = 1'b0; branchtaken = 1'b0; idexrt = 5'd0; ifidrs = 5'd0;

    // forwarding
    idexrs = 5'd7; exmemrd = 5'd7; memwbrd = 5'd7; exmemregwr = 1'b1; memwbregwr = 1'b1;
    #1 chk("fwda_exmem", {6'd0, forwarda}, 8'h02);
    exmemregwr = 1'b0;
    #1 chk("fwda_memwb", {6'd0, forwarda}, 8'h01);
    exmemregwr = 1'b1; exmemrd = 5'd0; memwbrd = 5'd0;
    #1 chk("fwda_r0", {6'd0, forwarda}, 8'h00);
    idexrs = 5'd0; exmemrd = 5'd0; memwbrd = 5'd0;
    #1 chk("fwda_rs0", {6'd0, forwarda}, 8'h00);
    idexrs = 5'd7; idexrt = 5'd3; exmemrd = 5'd7; memwbrd = 5'd3;
    #1 chk("fwdb_memwb", {6'd0, forwardb}, 8'h01);
    chk("fwda_exmem2", {6'd0, forwarda}, 8'h02);
    memwbregwr = 1'b0;
    #1 chk("fwdb_nowr", {6'd0, forwardb}, 8'h00);
    {idexrs, idexrt, exmemrd, memwbrd} = '0;
    {exmemregwr, memwbregwr} = '0;

    // three-cycle data-memory wait
    step();
    dmreq = 1'b1; dmready = 1'b0;
    #1 chk("freeze_run", ctl(), C_FREEZE);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("state_memwait", {6'd0, state}, 8'h02);
      chk("freeze_memwait", ctl(), C_FREEZE);
    end
    step();
    dmready = 1'b1;
    #1 chk("memwait_release", ctl(), C_RUN);
    step();
    dmreq = 1'b0;
    chk("state_back_run", {6'd0, state}, 8'h01);

    // freeze beats branch, then run to timeout (counter must restart at 0)
    dmreq = 1'b1; dmready = 1'b0; branchtaken = 1'b1;
    #1 chk("freeze_over_branch", ctl(), C_FREEZE);
    branchtaken = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("state_wait_count", {6'd0, state}, 8'h02);
    end
    chk("dmerr_before_to", {7'd0, dmerr}, 8'h00);
    step();
    chk("state_error", {6'd0, state}, 8'h03);
    chk("dmerr_set", {7'd0, dmerr}, 8'h01);
    chk("ctl_error", ctl(), C_FREEZE);
    dmreq = 1'b0; dmready = 1'b1; branchtaken = 1'b1;
    step();
    step();
    chk("error_sticky", {6'd0, state}, 8'h03);
    chk("dmerr_sticky", {7'd0, dmerr}, 8'h01);
    chk("ctl_error_hold", ctl(), C_FREEZE);
    branchtaken = 1'b0;

    // reset out of ERROR
    rst = 1'b1;
    #1 chk("ctl_rst_in_error", ctl(), C_INIT);
    step();
    rst = 1'b0;
    chk("state_rst_from_error", {6'd0, state}, 8'h00);
    chk("dmerr_cleared", {7'd0, dmerr}, 8'h00);
    for (int i = 0; i < 4; i++) step();
    chk("state_run_again", {6'd0, state}, 8'h01);

    // reset out of MEMWAIT
    dmreq = 1'b1; dmready = 1'b0;
    step();
    chk("state_memwait2", {6'd0, state}, 8'h02);
    rst = 1'b1;
    step();
    rst = 1'b0; dmreq = 1'b0;
    chk("state_rst_from_memwait", {6'd0, state}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
